fetch_stage: RTL and testbench

- Clocked instruction-fetch stage upstream of the single-cycle decode/execute datapath.
- Owns the program counter, drives the combinational instruction-memory address, and captures the fetched word plus PC+4 into an IF/ID register consumed by register-file decode, sign-extend and the branch adder.
- Accepts stall (hold) and redirect (branch/jump taken, flush) from downstream.

---
 rtl/fetch_stage_if.sv | 46 ++++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Fetch-stage bus: instruction-memory port, downstream control
//               (stall/redirect), IF/ID register outputs. Optional perf
//               counters appear when FETCH_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    modport master (
        output imem_addr, if_id_inst, if_id_pc4, if_id_valid, misalign_err,
               perf_fetched, perf_flushed,
        input  imem_data, stall, redirect_en, redirect_pc
    );
    modport slave (
        input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, misalign_err,
               perf_fetched, perf_flushed,
        output imem_data, stall, redirect_en, redirect_pc
    );
`else
    modport master (
        output imem_addr, if_id_inst, if_id_pc4, if_id_valid, misalign_err,
        input  imem_data, stall, redirect_en, redirect_pc
    );
    modport slave (
        input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, misalign_err,
        output imem_data, stall, redirect_en, redirect_pc
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage: PC register, combinational imem
//               address, IF/ID register with stall/redirect handling and a
//               sticky misaligned-target flag. FETCH_PERF_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_stage_if.master  bus
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + c_pc_step;

    // Redirect wins over stall; a stall freezes PC and IF/ID together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_inst  <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (bus.redirect_en) begin
            r_pc    <= {bus.redirect_pc[31:2], 2'b00};
            r_inst  <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc    <= w_pc_plus4;
            r_inst  <= bus.imem_data;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (bus.redirect_en && (bus.redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign bus.imem_addr    = r_pc;
    assign bus.if_id_inst   = r_inst;
    assign bus.if_id_pc4    = r_pc4;
    assign bus.if_id_valid  = r_valid;
    assign bus.misalign_err = r_misalign;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_flushed <= 32'd0;
        end else if (bus.redirect_en) begin
            r_perf_flushed <= r_perf_flushed + 32'd1;
        end else if (!bus.stall) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_flushed = r_perf_flushed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage (RESET_PC=0x100).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam logic [31:0] c_nop      = 32'h0000_0000;
    localparam logic [31:0] c_key      = 32'hA5A5_A5A5;

    logic   clk;
    logic   rst;
    integer checks;
    integer failures;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC (c_reset_pc),
        .NOP_WORD (c_nop)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory model: word = address ^ key.
    assign bus.imem_data = bus.imem_addr ^ c_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_addr", bus.imem_addr, c_reset_pc);
        chk("async_rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        chk("rst_addr", bus.imem_addr, c_reset_pc);
        chk("rst_inst", bus.if_id_inst, c_nop);
        chk("rst_pc4", bus.if_id_pc4, 32'd0);
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        rst = 1'b0;
        step();
        chk("first_inst", bus.if_id_inst, 32'hA5A5_A4A5);
        chk("first_pc4", bus.if_id_pc4, 32'h0000_0104);
        step();
        step();
        chk("three_addr", bus.imem_addr, 32'h0000_010C);
        chk("three_pc4", bus.if_id_pc4, 32'h0000_010C);
        chk("three_valid", {31'd0, bus.if_id_valid}, 32'd1);
        pulse_reset();
        chk("post_rst_addr", bus.imem_addr, c_reset_pc);
        chk("post_rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    endtask

    task automatic test_sequential();
        logic [31:0] prev;
        prev = 32'h0000_0100;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("seq_inst", bus.if_id_inst, prev ^ c_key);
            chk("seq_pc4", bus.if_id_pc4, prev + 32'd4);
            prev = prev + 32'd4;
            chk("seq_addr", bus.imem_addr, prev);
        end
    endtask

    task automatic test_stall();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0000;
        step();
        bus.redirect_en = 1'b0;
        step();
        step();
        chk("pre_stall_addr", bus.imem_addr, 32'h0000_0008);
        chk("pre_stall_inst", bus.if_id_inst, 32'hA5A5_A5A1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", bus.imem_addr, 32'h0000_0008);
            chk("stall_inst", bus.if_id_inst, 32'hA5A5_A5A1);
            chk("stall_pc4", bus.if_id_pc4, 32'h0000_0008);
            chk("stall_valid", {31'd0, bus.if_id_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        step();
        chk("unstall_pc4", bus.if_id_pc4, 32'h0000_000C);
        chk("unstall_inst", bus.if_id_inst, 32'hA5A5_A5AD);
    endtask

    task automatic test_redirect_beats_stall();
        bus.stall       = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        step();
        chk("rds_addr", bus.imem_addr, 32'h0000_0040);
        chk("rds_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rds_inst", bus.if_id_inst, c_nop);
        chk("rds_pc4", bus.if_id_pc4, 32'd0);
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        step();
        chk("rds_next_pc4", bus.if_id_pc4, 32'h0000_0044);
        chk("rds_next_inst", bus.if_id_inst, 32'hA5A5_A5E5);
    endtask

    task automatic test_back_to_back();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0080;
        step();
        chk("b2b_addr0", bus.imem_addr, 32'h0000_0080);
        chk("b2b_valid0", {31'd0, bus.if_id_valid}, 32'd0);
        bus.redirect_pc = 32'h0000_00C0;
        step();
        chk("b2b_addr1", bus.imem_addr, 32'h0000_00C0);
        chk("b2b_valid1", {31'd0, bus.if_id_valid}, 32'd0);
        bus.redirect_en = 1'b0;
    endtask

    task automatic test_misalign();
        chk("mis_before", {31'd0, bus.misalign_err}, 32'd0);
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0023;
        step();
        bus.redirect_en = 1'b0;
        chk("mis_addr", bus.imem_addr, 32'h0000_0020);
        chk("mis_flag", {31'd0, bus.misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);
        end
        chk("mis_run_addr", bus.imem_addr, 32'h0000_0048);
        pulse_reset();
        chk("mis_cleared", {31'd0, bus.misalign_err}, 32'd0);
    endtask

    task automatic test_wrap();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect_en = 1'b0;
        chk("wrap_pre_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        chk("wrap_pc4", bus.if_id_pc4, 32'h0000_0000);
        chk("wrap_inst", bus.if_id_inst, 32'h5A5A_5A59);
        chk("wrap_valid", {31'd0, bus.if_id_valid}, 32'd1);
        chk("wrap_misalign", {31'd0, bus.misalign_err}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", bus.perf_fetched, 32'd1);
        chk("perf_flushed", bus.perf_flushed, 32'd1);
`endif
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_beats_stall();
        test_back_to_back();
        test_misalign();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
